// File: rtl/jellyvl_synctimer_limitter_hyst.sv
// Limiter/hysteresis stage between the sync-timer correction receiver and the timer adjuster.
// Clamps each correction diff and requests a renew after consecutive out-of-range samples.
module jellyvl_synctimer_limitter_hyst #(
    parameter int unsigned TIMER_WIDTH   = 64,
    parameter int unsigned LIMIT_WIDTH   = TIMER_WIDTH,
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter int unsigned STAT_WIDTH    = 16,
    parameter bit          INIT_OVERRIDE = 1'b1,
    parameter bit          DEBUG         = 1'b0,
    parameter bit          SIMULATION    = 1'b0
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic signed [LIMIT_WIDTH-1:0] param_limit_min,
    input  logic signed [LIMIT_WIDTH-1:0] param_limit_max,
    input  logic        [COUNT_WIDTH-1:0] param_violation_limit,
    input  logic                          stat_clear,
    input  logic        [TIMER_WIDTH-1:0] current_time,
    input  logic        [TIMER_WIDTH-1:0] correct_time,
    input  logic                          correct_renew,
    input  logic                          correct_valid,
    output logic                          request_renew,
    output logic signed [LIMIT_WIDTH-1:0] adjust_diff,
    output logic                          adjust_valid,
    output logic                          over_flag,
    output logic                          under_flag,
    output logic        [STAT_WIDTH-1:0]  stat_violation,
    output logic        [STAT_WIDTH-1:0]  stat_renew
);

    if (DEBUG && SIMULATION) begin : g_debug
    end

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TRACK,
        ST_RENEW
    } state_t;

    state_t                         state;
    logic signed [TIMER_WIDTH-1:0]  s1_diff;
    logic                           s1_valid;
    logic                           s1_renew;
    logic        [COUNT_WIDTH-1:0]  violation_count;

    logic signed [TIMER_WIDTH-1:0]  limit_min_ext;
    logic signed [TIMER_WIDTH-1:0]  limit_max_ext;
    logic                           is_over;
    logic                           is_under;
    logic                           evaluate;
    logic                           violation;
    logic                           trigger;
    logic        [COUNT_WIDTH:0]    count_next;
    logic        [COUNT_WIDTH:0]    limit_eff;

    // Limits compared at full timer width so large diffs never alias into range.
    assign limit_min_ext = TIMER_WIDTH'(param_limit_min);
    assign limit_max_ext = TIMER_WIDTH'(param_limit_max);
    assign is_over       = s1_diff > limit_max_ext;
    assign is_under      = s1_diff < limit_min_ext;
    assign evaluate      = s1_valid && !s1_renew && (state == ST_TRACK);
    assign violation     = evaluate && (is_over || is_under);
    assign count_next    = {1'b0, violation_count} + (COUNT_WIDTH+1)'(1);
    assign limit_eff     = (param_violation_limit == '0) ? (COUNT_WIDTH+1)'(1)
                                                         : {1'b0, param_violation_limit};
    assign trigger       = violation && (count_next >= limit_eff);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_diff  <= '0;
            s1_valid <= 1'b0;
            s1_renew <= 1'b0;
        end else begin
            s1_diff  <= correct_time - current_time;
            s1_valid <= correct_valid;
            s1_renew <= correct_renew;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adjust_diff  <= '0;
            adjust_valid <= 1'b0;
            over_flag    <= 1'b0;
            under_flag   <= 1'b0;
        end else begin
            adjust_valid <= evaluate;
            if (evaluate) begin
                over_flag  <= is_over;
                under_flag <= is_under;
                if (is_over) begin
                    adjust_diff <= param_limit_max;
                end else if (is_under) begin
                    adjust_diff <= param_limit_min;
                end else begin
                    adjust_diff <= s1_diff[LIMIT_WIDTH-1:0];
                end
            end
        end
    end

    // A violation can only fire in ST_TRACK, so it never races the renew-accept branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (INIT_OVERRIDE) begin
                state <= ST_INIT;
            end else begin
                state <= ST_TRACK;
            end
            request_renew   <= INIT_OVERRIDE;
            violation_count <= '0;
        end else begin
            case (state)
                ST_TRACK: begin
                    request_renew <= 1'b0;
                    if (evaluate) begin
                        if (trigger) begin
                            state           <= ST_RENEW;
                            request_renew   <= 1'b1;
                            violation_count <= '0;
                        end else if (violation) begin
                            violation_count <= count_next[COUNT_WIDTH-1:0];
                        end else begin
                            violation_count <= '0;
                        end
                    end
                end
                ST_INIT, ST_RENEW: begin
                    request_renew <= 1'b1;
                    if (correct_valid && correct_renew) begin
                        state           <= ST_TRACK;
                        request_renew   <= 1'b0;
                        violation_count <= '0;
                    end
                end
                default: begin
                    state           <= ST_RENEW;
                    request_renew   <= 1'b1;
                    violation_count <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_violation <= '0;
            stat_renew     <= '0;
        end else if (stat_clear) begin
            stat_violation <= '0;
            stat_renew     <= '0;
        end else begin
            if (violation && (stat_violation != '1)) begin
                stat_violation <= stat_violation + STAT_WIDTH'(1);
            end
            if (trigger && (stat_renew != '1)) begin
                stat_renew <= stat_renew + STAT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_jellyvl_synctimer_limitter_hyst.sv
// Bench for jellyvl_synctimer_limitter_hyst: directed vector table, corner sequences,
// then randomized traffic checked against a sample-level reference model.
module tb_jellyvl_synctimer_limitter_hyst;

    localparam int TW = 16;
    localparam int LW = 12;
    localparam int CW = 8;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic                 reset = 1'b0;
    logic                 clk = 1'b0;
    logic signed [LW-1:0] param_limit_min = '0;
    logic signed [LW-1:0] param_limit_max = '0;
    logic        [CW-1:0] param_violation_limit = '0;
    logic                 stat_clear = 1'b0;
    logic        [TW-1:0] current_time = '0;
    logic        [TW-1:0] correct_time = '0;
    logic                 correct_renew = 1'b0;
    logic                 correct_valid = 1'b0;
    logic                 request_renew;
    logic signed [LW-1:0] adjust_diff;
    logic                 adjust_valid;
    logic                 over_flag;
    logic                 under_flag;
    logic        [SW-1:0] stat_violation;
    logic        [SW-1:0] stat_renew;

    jellyvl_synctimer_limitter_hyst #(
        .TIMER_WIDTH   (TW),
        .LIMIT_WIDTH   (LW),
        .COUNT_WIDTH   (CW),
        .STAT_WIDTH    (SW),
        .INIT_OVERRIDE (1'b1)
    ) dut (
        .reset                 (reset),
        .clk                   (clk),
        .param_limit_min       (param_limit_min),
        .param_limit_max       (param_limit_max),
        .param_violation_limit (param_violation_limit),
        .stat_clear            (stat_clear),
        .current_time          (current_time),
        .correct_time          (correct_time),
        .correct_renew         (correct_renew),
        .correct_valid         (correct_valid),
        .request_renew         (request_renew),
        .adjust_diff           (adjust_diff),
        .adjust_valid          (adjust_valid),
        .over_flag             (over_flag),
        .under_flag            (under_flag),
        .stat_violation        (stat_violation),
        .stat_renew            (stat_renew)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Limits/threshold as plain integers; the DUT inputs are driven from these.
    int lmin = -16;
    int lmax = 16;
    int vlim = 3;

    // Reference model: tracking mode, one in-flight sample, statistics as integers.
    bit m_tracking, m_req, m_av, m_over, m_under;
    bit m_pv, m_pr;
    int m_pd, m_adj, m_cnt, m_sv, m_sr;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wrap_diff(input int ct, input int cur);
        int d;
        d = (ct - cur) & 'hFFFF;
        if (d >= 32768) d -= 65536;
        return d;
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= SMAX) ? SMAX : x + 1;
    endfunction

    task automatic model_reset();
        m_tracking = 1'b0; m_req = 1'b1; m_av = 1'b0; m_over = 1'b0; m_under = 1'b0;
        m_pv = 1'b0; m_pr = 1'b0; m_pd = 0; m_adj = 0; m_cnt = 0; m_sv = 0; m_sr = 0;
    endtask

    task automatic model_edge(input bit v, input bit r, input int ct, input int cur, input bit clr);
        bit was_tracking;
        int need;
        was_tracking = m_tracking;
        m_av = 1'b0;
        if (m_pv && !m_pr && was_tracking) begin
            m_av    = 1'b1;
            m_over  = m_pd > lmax;
            m_under = m_pd < lmin;
            m_adj   = m_over ? lmax : (m_under ? lmin : m_pd);
            if (m_over || m_under) begin
                m_sv = sat_inc(m_sv);
                need = (vlim == 0) ? 1 : vlim;
                if (m_cnt + 1 >= need) begin
                    m_tracking = 1'b0;
                    m_req      = 1'b1;
                    m_sr       = sat_inc(m_sr);
                    m_cnt      = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                m_cnt = 0;
            end
        end
        if (!was_tracking && v && r) begin
            m_tracking = 1'b1;
            m_req      = 1'b0;
            m_cnt      = 0;
        end
        if (clr) begin
            m_sv = 0;
            m_sr = 0;
        end
        m_pv = v;
        m_pr = r;
        m_pd = wrap_diff(ct, cur);
    endtask

    task automatic check_model();
        chk("req",   int'(request_renew),       int'(m_req));
        chk("av",    int'(adjust_valid),        int'(m_av));
        chk("adj",   int'($signed(adjust_diff)), m_adj);
        chk("over",  int'(over_flag),           int'(m_over));
        chk("under", int'(under_flag),          int'(m_under));
        chk("s_vio", int'(stat_violation),      m_sv);
        chk("s_ren", int'(stat_renew),          m_sr);
    endtask

    task automatic apply_params();
        param_limit_min       = LW'(lmin);
        param_limit_max       = LW'(lmax);
        param_violation_limit = CW'(vlim);
    endtask

    task automatic step(input bit v, input bit r, input int ct, input int cur, input bit clr);
        @(negedge clk);
        correct_valid = v;
        correct_renew = r;
        correct_time  = TW'(ct);
        current_time  = TW'(cur);
        stat_clear    = clr;
        @(posedge clk);
        model_edge(v, r, ct, cur, clr);
        #1;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   int'(request_renew),  1);
        chk({tag, "_av"},    int'(adjust_valid),   0);
        chk({tag, "_adj"},   int'(adjust_diff),    0);
        chk({tag, "_over"},  int'(over_flag),      0);
        chk({tag, "_under"}, int'(under_flag),     0);
        chk({tag, "_svio"},  int'(stat_violation), 0);
        chk({tag, "_sren"},  int'(stat_renew),     0);
    endtask

    typedef struct {
        bit v; bit r; int ct; int cur;
        bit e_req; bit e_av; int e_adj; bit e_over; bit e_under; int e_sv; int e_sr;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Outputs observed right after each row's clock edge (two-cycle sample latency).
        tbl[0]  = '{1, 1, 1000, 1000,  0, 0,   0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1005, 1000,  0, 0,   0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1030, 1000,  0, 1,   5, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1030, 1000,  0, 1,  16, 1, 0, 1, 0};
        tbl[4]  = '{1, 0, 1030, 1000,  0, 1,  16, 1, 0, 2, 0};
        tbl[5]  = '{1, 0,  980, 1000,  1, 1,  16, 1, 0, 3, 1};
        tbl[6]  = '{1, 0,  980, 1000,  1, 0,  16, 1, 0, 3, 1};
        tbl[7]  = '{1, 1, 1000, 1000,  0, 0,  16, 1, 0, 3, 1};
        tbl[8]  = '{1, 0,  980, 1000,  0, 0,  16, 1, 0, 3, 1};
        tbl[9]  = '{1, 0,  980, 1000,  0, 1, -16, 0, 1, 4, 1};
        tbl[10] = '{1, 0, 1001, 1000,  0, 1, -16, 0, 1, 5, 1};
        tbl[11] = '{1, 0,  980, 1000,  0, 1,   1, 0, 0, 5, 1};
        tbl[12] = '{1, 0,  990, 1000,  0, 1, -16, 0, 1, 6, 1};
        tbl[13] = '{0, 0,    0, 1000,  0, 1, -10, 0, 0, 6, 1};
        tbl[14] = '{1, 0,    3, 65534, 0, 0, -10, 0, 0, 6, 1};
        tbl[15] = '{0, 0,    0, 1000,  0, 1,   5, 0, 0, 6, 1};

        apply_params();
        model_reset();
        #23;
        check_reset_values("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("init_req", int'(request_renew), 1);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].ct, tbl[i].cur, 1'b0);
            chk($sformatf("tbl%0d_req", i),   int'(request_renew),       int'(tbl[i].e_req));
            chk($sformatf("tbl%0d_av", i),    int'(adjust_valid),        int'(tbl[i].e_av));
            chk($sformatf("tbl%0d_adj", i),   int'($signed(adjust_diff)), tbl[i].e_adj);
            chk($sformatf("tbl%0d_over", i),  int'(over_flag),           int'(tbl[i].e_over));
            chk($sformatf("tbl%0d_under", i), int'(under_flag),          int'(tbl[i].e_under));
            chk($sformatf("tbl%0d_svio", i),  int'(stat_violation),      tbl[i].e_sv);
            chk($sformatf("tbl%0d_sren", i),  int'(stat_renew),          tbl[i].e_sr);
        end

        // Threshold 0 acts as 1: a single violation forces renew.
        vlim = 0;
        apply_params();
        step(1, 0, 1100, 1000, 0);
        step(0, 0, 0, 1000, 0);
        chk("lim0_req",  int'(request_renew),  1);
        chk("lim0_svio", int'(stat_violation), 7);
        chk("lim0_sren", int'(stat_renew),     2);

        // Non-renew samples in ST_RENEW are ignored entirely.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1000 + i * 37, 1000, 0);
            chk("renew_hold_req",  int'(request_renew),  1);
            chk("renew_hold_av",   int'(adjust_valid),   0);
            chk("renew_hold_svio", int'(stat_violation), 7);
            chk("renew_hold_sren", int'(stat_renew),     2);
        end
        step(1, 1, 2000, 2000, 0);
        chk("renew_accept_req", int'(request_renew), 0);
        step(1, 0, 1003, 1000, 0);
        step(0, 0, 0, 1000, 0);
        chk("after_renew_av",  int'(adjust_valid),         1);
        chk("after_renew_adj", int'($signed(adjust_diff)), 3);

        // Saturation of stat_violation, then clear winning over an increment.
        vlim = 255;
        apply_params();
        for (int i = 0; i < 20; i++) step(1, 0, 1100, 1000, 0);
        chk("sat_svio", int'(stat_violation), SMAX);
        step(1, 0, 1100, 1000, 1);
        chk("clr_svio", int'(stat_violation), 0);
        chk("clr_sren", int'(stat_renew),     0);
        step(0, 0, 0, 1000, 0);
        chk("post_clr_svio", int'(stat_violation), 1);

        // Asynchronous reset in the middle of back-to-back samples.
        step(1, 0, 1005, 1000, 0);
        step(1, 0, 1006, 1000, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        correct_valid = 1'b0;
        correct_renew = 1'b0;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("post_rst_av", int'(adjust_valid), 0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            int cur, off, ct;
            bit v, r, clr;
            if (i % 60 == 0) begin
                lmin = -int'($urandom_range(0, 60));
                lmax = int'($urandom_range(0, 60));
                vlim = int'($urandom_range(0, 4));
                apply_params();
            end
            cur = int'($urandom_range(0, 65535));
            off = int'($urandom_range(0, 180)) - 90;
            ct  = (cur + off) & 'hFFFF;
            v   = ($urandom_range(0, 99) < 80);
            r   = ($urandom_range(0, 99) < 12);
            clr = ($urandom_range(0, 99) < 3);
            step(v, r, ct, cur, clr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
